// File: rtl/uart_tx_fifo_send.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a registered-output serializer.
// The line is driven from a flop, so nothing on the inputs reaches uart_txd combinationally.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// LOAD  | one clock: take the popped FIFO byte into the output byte register
// START | start bit (low) for BAUD_DIV clocks
// DATA  | bits 0..7, LSB first, BAUD_DIV clocks each
// STOP  | stop bit (high) for BAUD_DIV clocks; pops straight into LOAD if more data waits
module uart_tx_fifo_send #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          uart_txd
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int BW       = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    rd_data;
    logic          wr_accept;
    logic          pop;

    state_t        state, state_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    tx_byte;
    logic          txd_d;
    logic          baud_last;

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign empty     = (fifo_count == '0);
    assign wr_accept = wr_en && !full;
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            // full is the pre-edge value, so a write while full is dropped even alongside a pop
            overflow <= wr_en && full;
            if (wr_accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_byte  <= '0;
            tx_busy  <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            tx_busy  <= (state_d != IDLE);
            uart_txd <= txd_d;
            if (state == LOAD)
                tx_byte <= rd_data;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7)
                        state_d = STOP;
                    else
                        bit_d = bit_idx + 3'd1;
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line value is derived from the next state so the registered output lines up with it
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = tx_byte[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_send.sv
// Directed bench for uart_tx_fifo_send with BAUD_DIV = 10 and a 64-entry FIFO.
// A negedge-sampling receiver model decodes the line and timestamps each start bit.
module tb_uart_tx_fifo_send;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_busy, uart_txd;
    logic [6:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo_send #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (5_000_000),
        .FIFO_DEPTH (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .uart_txd   (uart_txd)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    int rx_t[$];
    int stop_err = 0, ovf_cnt = 0, peak = 0, low_seen = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver model: start detected on first low sample, bits sampled mid-cell
    initial begin
        bit act;
        int cnt;
        int st;
        logic [7:0] sh;
        act = 1'b0;
        cnt = 0;
        st = 0;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (overflow) ovf_cnt++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (!uart_txd) low_seen++;
            if (!reset_n) begin
                act = 1'b0;
            end else if (!act) begin
                if (!uart_txd) begin
                    act = 1'b1;
                    cnt = 0;
                    st = cyc;
                end
            end else begin
                cnt++;
                if ((cnt % 10) == 5 && cnt > 10 && cnt < 90)
                    sh = {uart_txd, sh[7:1]};
                if (cnt == 95) begin
                    if (uart_txd !== 1'b1) stop_err++;
                    rx_q.push_back(sh);
                    rx_t.push_back(st);
                    act = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trackers();
        rx_q.delete();
        rx_t.delete();
        stop_err = 0;
        ovf_cnt = 0;
        peak = 0;
        low_seen = 0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("rx_byte_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((tx_busy || !empty) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle", 32'(tx_busy), 32'd0);
    endtask

    task automatic wait_empty(input int budget);
        int t = 0;
        while (!empty && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("wait_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] frame [32];
        int gap;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5, exact cycle timing
        clear_trackers();
        a5 = 8'hA5;
        wr_byte(a5);
        check("s1_e0_empty", 32'(empty), 32'd0);
        check("s1_e0_count", 32'(fifo_count), 32'd1);
        check("s1_e0_txd", 32'(uart_txd), 32'd1);
        check("s1_e0_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        check("s1_e1_empty", 32'(empty), 32'd1);
        check("s1_e1_busy", 32'(tx_busy), 32'd1);
        check("s1_e1_txd", 32'(uart_txd), 32'd1);
        @(negedge clk);
        check("s1_e2_start", 32'(uart_txd), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (10) @(negedge clk);
            check("s1_bit", 32'(uart_txd), 32'(a5[k]));
            check("s1_empty", 32'(empty), 32'd1);
        end
        repeat (19) @(negedge clk);
        check("s1_e101_busy", 32'(tx_busy), 32'd1);
        check("s1_e101_stop", 32'(uart_txd), 32'd1);
        @(negedge clk);
        check("s1_e102_busy", 32'(tx_busy), 32'd0);
        check("s1_rx_n", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("s1_rx_byte", 32'(rx_q[0]), 32'hA5);

        // Packer frame: 32 back-to-back writes
        clear_trackers();
        frame[0] = 8'h55; frame[1] = 8'hBB; frame[2] = 8'h01; frame[3] = 8'h1A;
        for (int i = 0; i < 26; i++) frame[4 + i] = 8'(i);
        frame[30] = 8'h3C; frame[31] = 8'hF0;
        for (int i = 0; i < 32; i++) wr_byte(frame[i]);
        wait_rx(32, 4000);
        for (int i = 0; i < rx_q.size(); i++) begin
            check("s2_byte", 32'(rx_q[i]), 32'(frame[i]));
            if (i > 0) check("s2_spacing", 32'(rx_t[i] - rx_t[i-1]), 32'd101);
        end
        check("s2_peak", 32'(peak), 32'd31);
        check("s2_ovf", 32'(ovf_cnt), 32'd0);
        check("s2_stop", 32'(stop_err), 32'd0);
        wait_idle(300);

        // Overflow: 70 writes, 65 accepted
        clear_trackers();
        for (int i = 0; i < 70; i++) begin
            wr_byte(8'(i));
            if (i == 63) check("s3_full_63", 32'(full), 32'd0);
            if (i == 64) check("s3_full_64", 32'(full), 32'd1);
        end
        check("s3_ovf_pulses", 32'(ovf_cnt), 32'd5);
        wait_rx(65, 7500);
        for (int i = 0; i < rx_q.size(); i++)
            check("s3_byte", 32'(rx_q[i]), 32'(i));
        wait_idle(300);
        check("s3_total", 32'(rx_q.size()), 32'd65);
        check("s3_stop", 32'(stop_err), 32'd0);

        // Wrap-around: three 40-byte bursts, each begun with the FIFO empty
        clear_trackers();
        for (int b = 0; b < 3; b++) begin
            wait_empty(5000);
            for (int i = 0; i < 40; i++) wr_byte(8'(b * 40 + i));
        end
        wait_rx(120, 13000);
        for (int i = 0; i < rx_q.size(); i++)
            check("s4_byte", 32'(rx_q[i]), 32'(i));
        wait_idle(300);

        // Reset during DATA bit 3 of the first of 10 queued bytes
        clear_trackers();
        for (int i = 0; i < 10; i++) wr_byte(8'hC0 + 8'(i));
        repeat (37) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("s5_txd", 32'(uart_txd), 32'd1);
        check("s5_count", 32'(fifo_count), 32'd0);
        check("s5_busy", 32'(tx_busy), 32'd0);
        check("s5_empty", 32'(empty), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_trackers();
        repeat (300) @(negedge clk);
        check("s5_quiet_rx", 32'(rx_q.size()), 32'd0);
        check("s5_quiet_low", 32'(low_seen), 32'd0);
        wr_byte(8'h3C);
        wait_rx(1, 300);
        if (rx_q.size() > 0) check("s5_new_byte", 32'(rx_q[0]), 32'h3C);
        wait_idle(300);

        // Second byte lands during STOP: direct STOP->LOAD, 11-clock high gap
        clear_trackers();
        wr_byte(8'h5A);
        repeat (91) @(negedge clk);
        check("s6_bit7", 32'(uart_txd), 32'd0);
        gap = 0;
        for (int c = 92; c <= 103; c++) begin
            @(negedge clk);
            if (uart_txd) gap++;
            if (c == 100) begin
                wr_en = 1'b1;
                wr_data = 8'h81;
            end
            if (c == 101) begin
                wr_en = 1'b0;
                check("s6_pending", 32'(empty), 32'd0);
            end
            if (c == 102) begin
                check("s6_load_busy", 32'(tx_busy), 32'd1);
                check("s6_load_pop", 32'(empty), 32'd1);
            end
        end
        check("s6_start", 32'(uart_txd), 32'd0);
        check("s6_gap", 32'(gap), 32'd11);
        wait_rx(2, 400);
        if (rx_q.size() > 1) begin
            check("s6_byte0", 32'(rx_q[0]), 32'h5A);
            check("s6_byte1", 32'(rx_q[1]), 32'h81);
            check("s6_spacing", 32'(rx_t[1] - rx_t[0]), 32'd101);
        end
        wait_idle(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
